// File: rtl/demuxes_rx.sv
// rtl/demuxes_rx.sv - 1-to-4 byte demux tree for the PHY receive path
// Redistributes a serialized byte stream round-robin onto four registered lanes.
module demuxes_rx #(
    parameter bit PACKED = 1'b0,
    parameter int DROP_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [7:0]        Entrada,
    input  logic              validEntrada,
    input  logic              alinear,
    output logic [7:0]        Salida0,
    output logic [7:0]        Salida1,
    output logic [7:0]        Salida2,
    output logic [7:0]        Salida3,
    output logic              validsalida0,
    output logic              validsalida1,
    output logic              validsalida2,
    output logic              validsalida3,
    output logic              group_strobe,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] lane;
    logic [7:0] stage [4];
    logic [3:0] sval;
    logic [3:0] sval_nxt;
    logic [7:0] cap_byte;
    logic       capture;
    logic       publish;
    logic       drop;

    always_comb begin
        capture  = PACKED ? validEntrada : 1'b1;
        cap_byte = validEntrada ? Entrada : 8'h00;
        lane     = alinear ? 2'd0 : ptr;
        // Realign wins over a lane-3 capture: the byte restarts a new group.
        publish  = capture && !alinear && (ptr == 2'd3);
        drop     = alinear && (ptr != 2'd0);

        ptr_nxt = ptr;
        if (capture) begin
            ptr_nxt = lane + 2'd1;
        end else if (alinear) begin
            ptr_nxt = 2'd0;
        end

        sval_nxt = alinear ? 4'b0000 : sval;
        if (publish) begin
            sval_nxt = 4'b0000;
        end else if (capture) begin
            sval_nxt[lane] = validEntrada;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            ptr          <= 2'd0;
            sval         <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                stage[i] <= 8'h00;
            end
            Salida0      <= 8'h00;
            Salida1      <= 8'h00;
            Salida2      <= 8'h00;
            Salida3      <= 8'h00;
            validsalida0 <= 1'b0;
            validsalida1 <= 1'b0;
            validsalida2 <= 1'b0;
            validsalida3 <= 1'b0;
            group_strobe <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            ptr          <= ptr_nxt;
            sval         <= sval_nxt;
            group_strobe <= publish;
            if (capture) begin
                stage[lane] <= cap_byte;
            end
            if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
            // Lane 3 is taken straight from the input so the word lands one cycle after capture.
            if (publish) begin
                Salida0      <= stage[0];
                Salida1      <= stage[1];
                Salida2      <= stage[2];
                Salida3      <= cap_byte;
                validsalida0 <= sval[0];
                validsalida1 <= sval[1];
                validsalida2 <= sval[2];
                validsalida3 <= validEntrada;
            end
        end
    end

endmodule

// File: tb/tb_demuxes_rx.sv
// tb/tb_demuxes_rx.sv - checks both capture modes of demuxes_rx against a group-list model
module tb_demuxes_rx;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Entrada = 8'h00;
    logic       validEntrada = 1'b0;
    logic       alinear = 1'b0;

    logic [7:0] sal [2][4];
    logic       vs  [2][4];
    logic       gs  [2];
    logic [7:0] dc  [2];

    int npass = 0;
    int ntotal = 0;

    // Model: pending bytes of the group being built, plus last published word.
    logic [7:0] pend_b [2][4];
    logic       pend_v [2][4];
    int         pend_n [2];
    logic [7:0] exp_s  [2][4];
    logic       exp_v  [2][4];
    logic       exp_gs [2];
    int         exp_dc [2];

    always #5 clk_4f = ~clk_4f;

    demuxes_rx #(.PACKED(1'b0), .DROP_W(8)) u_ts (
        .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada),
        .validEntrada(validEntrada), .alinear(alinear),
        .Salida0(sal[0][0]), .Salida1(sal[0][1]), .Salida2(sal[0][2]), .Salida3(sal[0][3]),
        .validsalida0(vs[0][0]), .validsalida1(vs[0][1]),
        .validsalida2(vs[0][2]), .validsalida3(vs[0][3]),
        .group_strobe(gs[0]), .drop_cnt(dc[0])
    );

    demuxes_rx #(.PACKED(1'b1), .DROP_W(8)) u_pk (
        .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada),
        .validEntrada(validEntrada), .alinear(alinear),
        .Salida0(sal[1][0]), .Salida1(sal[1][1]), .Salida2(sal[1][2]), .Salida3(sal[1][3]),
        .validsalida0(vs[1][0]), .validsalida1(vs[1][1]),
        .validsalida2(vs[1][2]), .validsalida3(vs[1][3]),
        .group_strobe(gs[1]), .drop_cnt(dc[1])
    );

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s mode%0d observed=%0h expected=%0h", tag, m, obs, expv);
    endtask

    task automatic model_edge(input int m, input logic r, input logic [7:0] d, input logic v, input logic al);
        if (r) begin
            pend_n[m] = 0;
            exp_gs[m] = 1'b0;
            exp_dc[m] = 0;
            for (int i = 0; i < 4; i++) begin
                exp_s[m][i] = 8'h00;
                exp_v[m][i] = 1'b0;
            end
            return;
        end
        exp_gs[m] = 1'b0;
        if (al) begin
            if (pend_n[m] != 0 && exp_dc[m] < 255) exp_dc[m]++;
            pend_n[m] = 0;
        end
        // Time-slot mode consumes every cycle; packed mode only valid bytes.
        if (m == 0 || v) begin
            pend_b[m][pend_n[m]] = v ? d : 8'h00;
            pend_v[m][pend_n[m]] = v;
            pend_n[m]++;
            if (pend_n[m] == 4) begin
                for (int i = 0; i < 4; i++) begin
                    exp_s[m][i] = pend_b[m][i];
                    exp_v[m][i] = pend_v[m][i];
                end
                exp_gs[m] = 1'b1;
                pend_n[m] = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic v, input logic al);
        reset = r;
        Entrada = d;
        validEntrada = v;
        alinear = al;
        @(posedge clk_4f);
        #1;
        for (int m = 0; m < 2; m++) begin
            model_edge(m, r, d, v, al);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("salida%0d", i), m, 32'(sal[m][i]), 32'(exp_s[m][i]));
                chk($sformatf("valid%0d", i), m, 32'(vs[m][i]), 32'(exp_v[m][i]));
            end
            chk("group_strobe", m, 32'(gs[m]), 32'(exp_gs[m]));
            chk("drop_cnt", m, 32'(dc[m]), 32'(exp_dc[m]));
        end
    endtask

    initial begin
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 0);

        // Full valid group, then idle cycles holding the word.
        step(0, 8'h11, 1, 0);
        step(0, 8'h22, 1, 0);
        step(0, 8'h33, 1, 0);
        step(0, 8'h44, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);

        // Time-slot group with one invalid slot.
        step(0, 8'hA1, 1, 0);
        step(0, 8'h5A, 0, 0);
        step(0, 8'hA3, 1, 0);
        step(0, 8'hA4, 1, 0);

        // Packed-mode group spread over idle cycles.
        step(0, 8'h01, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h02, 1, 0);
        step(0, 8'h03, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h04, 1, 0);

        // Realign after a partial group.
        step(1, 8'h00, 0, 0);
        step(0, 8'hB1, 1, 0);
        step(0, 8'hB2, 1, 0);
        step(0, 8'h55, 1, 1);
        step(0, 8'h66, 1, 0);
        step(0, 8'h77, 1, 0);
        step(0, 8'h88, 1, 0);
        step(0, 8'h00, 0, 0);

        // Realign on a lane-3 capture.
        step(0, 8'hC1, 1, 0);
        step(0, 8'hC2, 1, 0);
        step(0, 8'hC3, 1, 0);
        step(0, 8'hC4, 1, 1);

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++) step(0, 8'($urandom), 1, 1);
        chk("drop_sat", 0, 32'(dc[0]), 32'd255);
        chk("drop_sat", 1, 32'(dc[1]), 32'd255);

        // Reset in the middle of a group.
        step(0, 8'hD1, 1, 0);
        step(0, 8'hD2, 1, 0);
        step(1, 8'hD3, 1, 0);
        step(0, 8'hE1, 1, 0);
        step(0, 8'hE2, 1, 0);
        step(0, 8'hE3, 1, 0);
        step(0, 8'hE4, 1, 0);

        // Randomised traffic with occasional realign and rare reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
